// File: rtl/hazard_scoreboard_unit.sv
// In-flight writer tracker driving decode stall and registered EX forward selects.
// Optional stall counter port/logic: define HAZARD_STATS_EN.
module hazard_scoreboard_unit #(
  parameter int ADDR_W     = 5,
  parameter int STAGES     = 3,
  parameter int LOAD_STAGE = 2,
  parameter int SEL_W      = $clog2(STAGES + 2)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              w_id_valid,
  input  logic [ADDR_W-1:0] w_id_rs_addr,
  input  logic [ADDR_W-1:0] w_id_rt_addr,
  input  logic              w_id_uses_rs,
  input  logic              w_id_uses_rt,
  input  logic              w_id_rt_late,
  input  logic              w_id_rs_early,
  input  logic [ADDR_W-1:0] w_id_dst_addr,
  input  logic              w_id_writes,
  input  logic              w_id_is_load,
  input  logic              w_flush,
  input  logic              w_freeze,
  output logic              w_stall,
  output logic [SEL_W-1:0]  w_fwd_rs_sel,
  output logic [SEL_W-1:0]  w_fwd_rt_sel
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]       w_stall_count
`endif
);

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] dst;
    logic              writes;
    logic              is_load;
  } entry_t;

  entry_t           slot_q [1:STAGES];
  entry_t           id_entry;
  logic             rs_hit, rt_hit;
  logic             rs_ld, rt_ld;
  int               rs_idx, rt_idx;
  logic             rs_ex, rt_ex, rt_lt, rs_er;
  logic             stall_any, bubble;
  logic [SEL_W-1:0] rs_sel_d, rt_sel_d;

  function automatic logic hit(entry_t e, logic [ADDR_W-1:0] src);
    return e.valid && e.writes && (e.dst == src) && (src != '0);
  endfunction

  // Slot STAGES retires this edge, so its value comes from the hold register.
  function automatic logic [SEL_W-1:0] fwd(int idx);
    return (idx == STAGES) ? SEL_W'(STAGES + 1) : SEL_W'(idx + 1);
  endfunction

  always_comb begin
    rs_hit = 1'b0;
    rs_ld  = 1'b0;
    rs_idx = 0;
    rt_hit = 1'b0;
    rt_ld  = 1'b0;
    rt_idx = 0;
    // Oldest first, so the youngest match overwrites.
    for (int j = STAGES; j >= 1; j--) begin
      if (hit(slot_q[j], w_id_rs_addr)) begin
        rs_hit = 1'b1;
        rs_ld  = slot_q[j].is_load;
        rs_idx = j;
      end
      if (hit(slot_q[j], w_id_rt_addr)) begin
        rt_hit = 1'b1;
        rt_ld  = slot_q[j].is_load;
        rt_idx = j;
      end
    end
  end

  always_comb begin
    rs_ex = w_id_valid & w_id_uses_rs;
    rt_ex = w_id_valid & w_id_uses_rt & ~w_id_rt_late;
    rt_lt = w_id_valid & w_id_uses_rt & w_id_rt_late;
    rs_er = w_id_valid & w_id_rs_early;
    stall_any = 1'b0;
    if (rs_ex && rs_hit && rs_ld && (rs_idx + 1 <= LOAD_STAGE))
      stall_any = 1'b1;
    if (rt_ex && rt_hit && rt_ld && (rt_idx + 1 <= LOAD_STAGE))
      stall_any = 1'b1;
    if (rt_lt && rt_hit && rt_ld && (rt_idx + 2 <= LOAD_STAGE))
      stall_any = 1'b1;
    if (rs_er && rs_hit)
      stall_any = 1'b1;
    w_stall = stall_any & ~w_flush;
    bubble  = w_stall | w_flush | ~w_id_valid;
    rs_sel_d = (rs_ex && rs_hit) ? fwd(rs_idx) : '0;
    rt_sel_d = (w_id_valid && w_id_uses_rt && rt_hit) ? fwd(rt_idx) : '0;
    id_entry.valid   = 1'b1;
    id_entry.dst     = w_id_dst_addr;
    id_entry.writes  = w_id_writes;
    id_entry.is_load = w_id_is_load;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int k = 1; k <= STAGES; k++)
        slot_q[k] <= '0;
      w_fwd_rs_sel <= '0;
      w_fwd_rt_sel <= '0;
    end else if (!w_freeze) begin
      for (int k = STAGES; k >= 2; k--)
        slot_q[k] <= slot_q[k-1];
      slot_q[1]    <= bubble ? '0 : id_entry;
      w_fwd_rs_sel <= bubble ? '0 : rs_sel_d;
      w_fwd_rt_sel <= bubble ? '0 : rt_sel_d;
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clock) begin
    if (!reset_n)
      w_stall_count <= '0;
    else if (!w_freeze && w_stall && (w_stall_count != '1))
      w_stall_count <= w_stall_count + 32'd1;
  end
`endif

endmodule
